// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler owning HI/LO; MD_SCHED_MADD_EN enables MADD/MSUB (ops 6/7)
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] ph, pl;
    logic [63:0] smul, umul, res;
    logic [31:0] mag_a, mag_b, sq_u, sr_u, sq, sr, uq, ur;
    logic        timed;
    logic [3:0]  dur;
`ifdef MD_SCHED_MADD_EN
    assign timed = ~(op[2] & ~op[1]);
`else
    assign timed = ~op[2];
`endif
    assign dur   = (op[2:1] == 2'b01) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    assign busy  = (state == RUN);
    assign stall = d_is_md & (busy | start);
    // Result computed at issue time; a zero divisor or unused op leaves HI/LO as they were
    always_comb begin
        smul  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        umul  = {32'b0, a} * {32'b0, b};
        mag_a = a[31] ? -a : a;
        mag_b = b[31] ? -b : b;
        sq_u  = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
        sr_u  = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
        sq    = (a[31] ^ b[31]) ? -sq_u : sq_u;
        sr    = a[31] ? -sr_u : sr_u;
        uq    = (b == 32'd0) ? 32'd0 : a / b;
        ur    = (b == 32'd0) ? 32'd0 : a % b;
        res   = (op == 3'd0) ? smul :
                (op == 3'd1) ? umul :
                (op == 3'd2) ? ((b == 32'd0) ? {hi, lo} : {sr, sq}) :
                (op == 3'd3) ? ((b == 32'd0) ? {hi, lo} : {ur, uq}) :
                (op == 3'd6) ? {hi, lo} + smul :
                               {hi, lo} - smul;
    end
    // IDLE accepts ops; RUN counts down and commits the pending result on the last cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            ph    <= 32'd0;
            pl    <= 32'd0;
        end else if (state == IDLE) begin
            if (start && timed) begin
                {ph, pl} <= res;
                cnt      <= dur;
                state    <= RUN;
            end else if (start && op == 3'd4) begin
                hi <= a;
            end else if (start && op == 3'd5) begin
                lo <= a;
            end
        end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                {hi, lo} <= {ph, pl};
                state    <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: scoreboard bench for md_sched against an arithmetic reference model
module tb_md_sched;
    localparam int MULTN = 5;
    localparam int DIVN  = 10;
`ifdef MD_SCHED_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif
    typedef struct {int at; logic b; logic [31:0] h; logic [31:0] l; int id;} chk_t;
    typedef struct {int at; logic v;} stl_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, d_is_md = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0, b = 32'd0;
    logic        busy, stall;
    logic [31:0] hi, lo;
    int          cyc = 0, cmp = 0, err = 0, nid = 0, busy_until = 0;
    logic        done = 1'b0, fin = 1'b0;
    logic [31:0] mhi = 32'd0, mlo = 32'd0;
    chk_t        rq[$];
    stl_t        sq[$];

    md_sched #(.MULT_CYCLES(MULTN), .DIV_CYCLES(DIVN)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .d_is_md(d_is_md), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, y, input logic [63:0] hl);
        longint sx, sy, ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        case (o)
            3'd0: return sx * sy;
            3'd1: return ux * uy;
            3'd2: return (y == 0) ? hl : {32'(sx % sy), 32'(sx / sy)};
            3'd3: return (y == 0) ? hl : {32'(ux % uy), 32'(ux / uy)};
            3'd4: return {x, hl[31:0]};
            3'd5: return {hl[63:32], x};
            3'd6: return MADD_EN ? hl + sx * sy : hl;
            default: return MADD_EN ? hl - sx * sy : hl;
        endcase
    endfunction

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            default: return $urandom();
        endcase
    endfunction

    task automatic push(input int at, input logic bz, input logic [31:0] h, l);
        chk_t c;
        c.at = at; c.b = bz; c.h = h; c.l = l; c.id = nid;
        nid++;
        rq.push_back(c);
    endtask

    task automatic step(input logic st, input logic [2:0] o, input logic [31:0] xa, xb, input logic d, input logic r);
        int e, n;
        logic bn, tm;
        stl_t s;
        @(posedge clk);
        #1;
        start = st; op = o; a = xa; b = xb; d_is_md = d; rst = r;
        e = cyc + 1;
        bn = cyc < busy_until;
        s.at = cyc;
        s.v = d & (bn | st);
        sq.push_back(s);
        if (r) begin
            while (rq.size() != 0 && rq[$].at >= e) void'(rq.pop_back());
            mhi = 32'd0;
            mlo = 32'd0;
            busy_until = 0;
            push(e, 1'b0, 32'd0, 32'd0);
        end else if (st && !bn) begin
            tm = (o < 3'd4) || (MADD_EN && o >= 3'd6);
            n = (o == 3'd2 || o == 3'd3) ? DIVN : MULTN;
            if (tm) begin
                push(e + n - 1, 1'b1, mhi, mlo);
                {mhi, mlo} = model(o, xa, xb, {mhi, mlo});
                push(e + n, 1'b0, mhi, mlo);
                busy_until = e + n;
            end else begin
                {mhi, mlo} = model(o, xa, xb, {mhi, mlo});
                push(e, 1'b0, mhi, mlo);
            end
        end
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] xa, xb, input logic d);
        step(1'b1, o, xa, xb, d, 1'b0);
        while (cyc + 1 < busy_until) step(1'b0, 3'd0, 32'd0, 32'd0, d, 1'b0);
    endtask

    always @(negedge clk) begin
        chk_t x;
        stl_t s;
        while (rq.size() != 0 && rq[0].at <= cyc) begin
            x = rq.pop_front();
            cmp++;
            if (x.at != cyc || busy !== x.b || hi !== x.h || lo !== x.l) begin
                err++;
                $display("FAIL res#%0d cycle %0d: got busy=%b hi=%h lo=%h, expected busy=%b hi=%h lo=%h due %0d",
                         x.id, cyc, busy, hi, lo, x.b, x.h, x.l, x.at);
            end
        end
        while (sq.size() != 0 && sq[0].at <= cyc) begin
            s = sq.pop_front();
            cmp++;
            if (s.at != cyc || stall !== s.v) begin
                err++;
                $display("FAIL stall cycle %0d: got %b, expected %b due %0d", cyc, stall, s.v, s.at);
            end
        end
        if (done && !fin) begin
            cmp++;
            if (rq.size() != 0 || sq.size() != 0) begin
                err++;
                $display("FAIL drain: got %0d/%0d checks left, expected 0/0", rq.size(), sq.size());
            end
            fin = 1'b1;
        end
    end

    initial begin
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 3'd0, 32'hFFFFFFFD, 32'd5, 1'b1, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step(1'b1, 3'd5, 32'hDEADBEEF, 32'd0, 1'b1, 1'b0);
        while (cyc + 1 < busy_until) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        run(3'd3, 32'd7, 32'd2, 1'b0);
        run(3'd2, 32'hFFFFFFF9, 32'd2, 1'b1);
        run(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run(3'd4, 32'h11, 32'd0, 1'b0);
        run(3'd5, 32'h22, 32'd0, 1'b0);
        run(3'd2, 32'd1234, 32'd0, 1'b0);
        run(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run(3'd4, 32'd0, 32'd0, 1'b0);
        run(3'd5, 32'hFFFFFFFF, 32'd0, 1'b0);
        run(3'd6, 32'd1, 32'd1, 1'b0);
        run(3'd7, 32'd3, 32'hFFFFFFFE, 1'b0);
        run(3'd4, 32'h55, 32'd0, 1'b0);
        step(1'b1, 3'd2, 32'd100, 32'd7, 1'b1, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        repeat (12) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        push(cyc + 1, 1'b0, 32'd0, 32'd0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), rv(), rv(),
                 1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
        repeat (12) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        done = 1'b1;
        wait (fin);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule

// File: doc/md_sched.md
# md_sched

Multiply/divide unit scheduler for the P6 pipeline. Accepts mult/div/mthi/mtlo operations issued from the E stage and runs them with fixed multi-cycle latency. Owns the HI/LO registers and raises `stall` to freeze F/D while a D-stage instruction needs the unit and the unit is occupied. HI/LO feed the `MD` write-data source carried down the M/W pipeline registers.

## Interface
Parameters:
- `MULT_CYCLES`, 5, busy duration of mult/multu (and madd/msub); legal range 1..15.
- `DIV_CYCLES`, 10, busy duration of div/divu; legal range 1..15.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  E-stage instruction is an md-unit op; sampled at `clk` posedge.
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
- `a`  in  32  rs operand (forwarded value).
- `b`  in  32  rt operand (forwarded value).
- `d_is_md`  in  1  D-stage instruction is mult/div/madd/msub/mthi/mtlo/mfhi/mflo.
- `busy`  out  1  unit running a timed op.
- `stall`  out  1  pipeline freeze request to F/D, combinational.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, RUN. 4-bit down counter `cnt`; 64-bit pending result `{ph,pl}`.
- IDLE, `start`=1, op MULT/MULTU/DIV/DIVU/MADD/MSUB: latch computed result into `{ph,pl}`, `cnt` <= MULT_CYCLES or DIV_CYCLES, go RUN.
- IDLE, `start`=1, op MTHI/MTLO: `hi`/`lo` <= `a` at that edge; stays IDLE; `busy` never asserts.
- RUN: `cnt` decrements each edge. On the edge where `cnt`==1, `{hi,lo}` <= `{ph,pl}` and go IDLE.
- `start` in RUN: ignored entirely (no latch, no HI/LO write). The stall rule guarantees this does not occur in-program.
- `busy` = (state==RUN).
- `stall` = `d_is_md` & (`busy` | `start`).
- MULT: signed 64-bit a*b; MULTU: unsigned. HI = [63:32], LO = [31:0].
- DIV/DIVU: LO = quotient truncated toward zero, HI = remainder with sign of dividend. DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- `b`==0 for DIV/DIVU: runs full DIV_CYCLES; HI/LO unchanged at completion.
- MADD/MSUB: `{ph,pl}` = `{hi,lo}` ± signed(a*b), using HI/LO values at start time.
- Reset: state IDLE, `cnt`=0, `busy`=0, `hi`=0, `lo`=0, pending cleared. Reset mid-RUN aborts the op; no HI/LO update.

## Timing
- Start sampled at edge k: `busy` is high from after edge k until edge k+N, i.e. exactly N cycles (N = MULT_CYCLES or DIV_CYCLES). HI/LO hold the new value after edge k+N.
- MTHI/MTLO: visible on `hi`/`lo` one cycle after the start edge.
- `stall` is combinational in the start cycle and all `busy` cycles. It drops in the cycle after HI/LO update, so a following mfhi/mflo reads the new value.
- Back-to-back: a new start may be accepted in the first IDLE cycle after completion.
- `rst` takes priority over `start` on the same edge.

## Configuration
- `MD_SCHED_MADD_EN` defined: ops 6/7 behave as MADD/MSUB above.
- Undefined: ops 6/7 are no-ops. No RUN entry, no busy, HI/LO unchanged; stall logic unaffected.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=5 -> `busy` high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIVU a=7, b=2 -> `busy` 10 cycles, LO=3, HI=1. DIV a=0xFFFFFFF9 (−7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV b=0 with HI=0x11, LO=0x22 -> `busy` 10 cycles; HI=0x11, LO=0x22 retained.
- MULT started, `d_is_md`=1 held -> `stall`=1 in the start cycle plus 5 busy cycles (6 total), 0 the next cycle; a MTLO `start` during busy does not change LO.
- DIV started, `rst` at third busy cycle -> next cycle `busy`=0, HI=LO=0; no later update.
- With `MD_SCHED_MADD_EN`: HI=0, LO=0xFFFFFFFF, MADD a=1, b=1 -> HI=1, LO=0 after 5 cycles. Without the macro: same stimulus -> `busy` stays 0, HI/LO unchanged.
